// File: rtl/transmitter.sv
// Serial transmitter: 4-byte FIFO feeding start / 8 data (LSB first) / even parity / stop frames, one bit per clk.
// Pop-to-start-bit latency 1 cycle; in_ready deasserts only while the FIFO holds 4 bytes.
module transmitter (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       tx,
  output logic       busy,
  output logic       frame_done,
  output logic [2:0] fifo_count
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t     r_state;
  logic [7:0] r_mem [4];
  logic [1:0] r_wr_ptr;
  logic [1:0] r_rd_ptr;
  logic [2:0] r_count;
  logic [2:0] r_idx;
  logic [7:0] r_shift;
  logic       r_parity;
  logic       r_tx;
  logic       r_busy;
  logic       r_frame_done;

  logic       w_push;
  logic       w_pop;
  logic [2:0] w_idx_nxt;

  assign in_ready   = (r_count != 3'd4);
  assign w_push     = in_valid && in_ready;
  assign w_pop      = (r_state == IDLE) && enable && (r_count != 3'd0);
  assign w_idx_nxt  = r_idx + 3'd1;

  assign tx         = r_tx;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;
  assign fifo_count = r_count;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= in_data;
    end
  end

  // Pointers wrap naturally at 4 entries; push and pop on the same edge cancel in the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= 2'd0;
      r_rd_ptr <= 2'd0;
      r_count  <= 3'd0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 2'd1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 2'd1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // tx is loaded with the bit belonging to the state being entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_idx        <= 3'd0;
      r_shift      <= 8'd0;
      r_parity     <= 1'b0;
      r_tx         <= 1'b1;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_tx         <= 1'b1;
          r_busy       <= 1'b0;
          r_frame_done <= 1'b0;
          if (w_pop) begin
            r_shift  <= r_mem[r_rd_ptr];
            r_parity <= ^r_mem[r_rd_ptr];
            r_tx     <= 1'b0;
            r_busy   <= 1'b1;
            r_state  <= START;
          end
        end
        START: begin
          r_idx   <= 3'd0;
          r_tx    <= r_shift[0];
          r_state <= DATA;
        end
        DATA: begin
          if (r_idx == 3'd7) begin
            r_tx    <= r_parity;
            r_state <= PARITY;
          end else begin
            r_idx <= w_idx_nxt;
            r_tx  <= r_shift[w_idx_nxt];
          end
        end
        PARITY: begin
          r_tx         <= 1'b1;
          r_frame_done <= 1'b1;
          r_state      <= STOP;
        end
        STOP: begin
          r_tx         <= 1'b1;
          r_busy       <= 1'b0;
          r_frame_done <= 1'b0;
          r_idx        <= 3'd0;
          r_state      <= IDLE;
        end
        default: begin
          r_tx         <= 1'b1;
          r_busy       <= 1'b0;
          r_frame_done <= 1'b0;
          r_state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_transmitter.sv
// Randomized bench for transmitter: queue-level FIFO model plus a frame-decoding monitor scoreboard.
module tb_transmitter;

  logic       clk;
  logic       rst;
  logic       enable;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       tx;
  logic       busy;
  logic       frame_done;
  logic [2:0] fifo_count;

  transmitter dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .tx         (tx),
    .busy       (busy),
    .frame_done (frame_done),
    .fifo_count (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Model: bytes waiting in the FIFO, bytes already launched onto the line, edges since the last launch.
  logic [7:0] mq[$];
  logic [7:0] exp_q[$];
  int         since = 100;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle(input logic v, input logic [7:0] d, input logic en, input logic r);
    logic do_pop;
    logic do_push;
    @(negedge clk);
    chk("fifo_count", int'(fifo_count), mq.size());
    chk("in_ready", int'(in_ready), int'(mq.size() < 4));
    chk("busy", int'(busy), int'(since <= 10));
    chk("frame_done", int'(frame_done), int'(since == 10));
    if (since > 10) chk("tx_idle", int'(tx), 1);
    in_valid = v;
    in_data  = d;
    enable   = en;
    rst      = r;
    if (r) begin
      mq.delete();
      exp_q.delete();
      since = 100;
      #1;
      chk("rst_tx", int'(tx), 1);
      chk("rst_busy", int'(busy), 0);
      chk("rst_in_ready", int'(in_ready), 1);
      chk("rst_fifo_count", int'(fifo_count), 0);
    end else begin
      since   = (since < 100) ? since + 1 : 100;
      do_pop  = en && (since >= 12) && (mq.size() > 0);
      do_push = v && (mq.size() < 4);
      if (do_pop) begin
        exp_q.push_back(mq.pop_front());
        since = 0;
      end
      if (do_push) mq.push_back(d);
    end
  endtask

  // Monitor: decodes each frame from tx and checks it against the next launched byte.
  initial begin
    logic [10:0] bits;
    logic        fd;
    logic        aborted;
    logic [7:0]  exp;
    forever begin
      @(negedge clk);
      if (!rst && tx === 1'b0) begin
        bits    = '0;
        fd      = 1'b0;
        aborted = 1'b0;
        for (int i = 1; i < 11; i++) begin
          @(negedge clk);
          if (rst) begin
            aborted = 1'b1;
            break;
          end
          bits[i] = tx;
          if (i == 10) fd = frame_done;
        end
        if (!aborted) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_frame", 1, 0);
          end else begin
            exp = exp_q.pop_front();
            chk("frame_data", int'(bits[8:1]), int'(exp));
            chk("frame_parity", int'(bits[9]), int'(^exp));
            chk("frame_stop_done", int'({bits[10], fd}), 3);
          end
        end
      end
    end
  end

  initial begin
    int rst_cnt;
    int guard;
    logic [7:0] full_bytes [5];
    full_bytes[0] = 8'h55; full_bytes[1] = 8'h01; full_bytes[2] = 8'hFF;
    full_bytes[3] = 8'h80; full_bytes[4] = 8'h3C;
    rst = 1'b1; enable = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    cycle(0, 8'h00, 0, 1);
    cycle(0, 8'h00, 0, 1);

    // Single byte 0xAE
    cycle(1, 8'hAE, 1, 0);
    repeat (16) cycle(0, 8'h00, 1, 0);

    // Full FIFO with enable low, fifth byte rejected, then drain in order
    foreach (full_bytes[i]) cycle(1, full_bytes[i], 0, 0);
    repeat (3) cycle(0, 8'h00, 0, 0);
    repeat (55) cycle(0, 8'h00, 1, 0);

    // Push/pop collision with two bytes queued
    cycle(1, 8'h12, 0, 0);
    cycle(1, 8'h34, 0, 0);
    cycle(0, 8'h00, 0, 0);
    cycle(1, 8'h56, 1, 0);
    repeat (45) cycle(0, 8'h00, 1, 0);

    // Enable drop mid-frame with two bytes queued
    cycle(1, 8'hA5, 1, 0);
    cycle(1, 8'h0F, 1, 0);
    cycle(1, 8'hC3, 1, 0);
    repeat (4) cycle(0, 8'h00, 1, 0);
    repeat (30) cycle(0, 8'h00, 0, 0);
    repeat (30) cycle(0, 8'h00, 1, 0);

    // Reset during PARITY, then silence until new pushes
    cycle(1, 8'h99, 1, 0);
    cycle(1, 8'h77, 1, 0);
    guard = 0;
    while (since != 9 && guard < 40) begin
      cycle(0, 8'h00, 1, 0);
      guard++;
    end
    chk("reach_parity", int'(since == 9), 1);
    cycle(0, 8'h00, 1, 1);
    cycle(0, 8'h00, 1, 1);
    repeat (20) cycle(0, 8'h00, 1, 0);

    // Random traffic with occasional two-cycle resets
    rst_cnt = 0;
    for (int n = 0; n < 900; n++) begin
      if (rst_cnt == 0 && $urandom_range(0, 249) == 0) rst_cnt = 2;
      cycle(logic'($urandom_range(0, 2) == 0), 8'($urandom), logic'($urandom_range(0, 5) != 0),
            logic'(rst_cnt > 0));
      if (rst_cnt > 0) rst_cnt--;
    end

    // Drain
    guard = 0;
    while ((mq.size() != 0 || since <= 12) && guard < 200) begin
      cycle(0, 8'h00, 1, 0);
      guard++;
    end
    chk("drain_timeout", int'(guard < 200), 1);
    repeat (3) cycle(0, 8'h00, 1, 0);
    chk("frames_outstanding", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
